// File: rtl/pulse_timer_pkg.sv
// ----------------------------------------------------------------------------
// | pulse_timer_pkg                                                          |
// | Shared state encodings for the pulse_timer channel FSMs.                 |
// | Revision: 1.0                                                            |
// ----------------------------------------------------------------------------
`default_nettype none

package pulse_timer_pkg;

  localparam int ST_W = 2;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE         = 2'b00,
    ST_ACTIVE       = 2'b01,
    ST_WAIT_RELEASE = 2'b10
  } state_e;

endpackage

`default_nettype wire

// File: rtl/pulse_timer_chan.sv
// ----------------------------------------------------------------------------
// | pulse_timer_chan                                                         |
// | One trigger channel: synchronizer, one-shot FSM, hold counter, done.     |
// | Optional PULSE_TIMER_RETRIG_EN: trigger re-press in ACTIVE reloads count.|
// | Revision: 1.0                                                            |
// ----------------------------------------------------------------------------
`default_nettype none

module pulse_timer_chan
  import pulse_timer_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic             tick_i,
  input  logic             trig_i,
  input  logic [CNT_W-1:0] hold_ticks_i,
  output state_e           state_o,
  output logic             done_o
);

  logic             sync1_q;
  logic             trig_s_q;
  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             done_q;
  logic [CNT_W-1:0] load_d;
  logic             retrig_d;

  // A zero hold length still produces a one-tick pulse.
  assign load_d = (hold_ticks_i == '0) ? CNT_W'(1) : hold_ticks_i;

`ifdef PULSE_TIMER_RETRIG_EN
  logic trig_s_d_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      trig_s_d_q <= 1'b0;
    end else begin
      trig_s_d_q <= trig_s_q;
    end
  end

  assign retrig_d = trig_s_q & ~trig_s_d_q;
`else
  assign retrig_d = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      trig_s_q <= 1'b0;
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      sync1_q  <= trig_i;
      trig_s_q <= sync1_q;
      done_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (trig_s_q && en_i) begin
            state_q <= ST_ACTIVE;
            cnt_q   <= load_d;
          end
        end
        ST_ACTIVE: begin
          if (en_i) begin
            // A reload takes priority over a coincident final tick.
            if (retrig_d) begin
              cnt_q <= load_d;
            end else if (tick_i) begin
              cnt_q <= cnt_q - CNT_W'(1);
              if (cnt_q == CNT_W'(1)) begin
                state_q <= trig_s_q ? ST_WAIT_RELEASE : ST_IDLE;
                done_q  <= 1'b1;
              end
            end
          end
        end
        ST_WAIT_RELEASE: begin
          if (!trig_s_q) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign state_o = state_q;
  assign done_o  = done_q;

endmodule

`default_nettype wire

// File: rtl/pulse_timer.sv
// ----------------------------------------------------------------------------
// | pulse_timer                                                              |
// | Multi-channel one-shot controller with shared tick prescaler.            |
// | Optional PULSE_TIMER_RETRIG_EN enables re-trigger reload in each channel.|
// | Revision: 1.0                                                            |
// ----------------------------------------------------------------------------
`default_nettype none

module pulse_timer
  import pulse_timer_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 8,
  parameter int TICK_DIV = 33554432
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [CHANNELS-1:0]   trig,
  input  logic [CNT_W-1:0]      hold_ticks,
  output logic [CHANNELS-1:0]   pulse,
  output logic [CHANNELS-1:0]   done,
  output logic                  busy,
  output logic                  tick,
  output logic [2*CHANNELS-1:0] state_out
);

  localparam int              PRE_W    = $clog2(TICK_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  logic [PRE_W-1:0] presc_q;

  assign tick = en && (presc_q == PRE_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
    end else if (en) begin
      presc_q <= tick ? '0 : presc_q + PRE_W'(1);
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    state_e st;

    pulse_timer_chan #(
      .CNT_W (CNT_W)
    ) u_chan (
      .clk          (clk),
      .reset        (reset),
      .en_i         (en),
      .tick_i       (tick),
      .trig_i       (trig[g]),
      .hold_ticks_i (hold_ticks),
      .state_o      (st),
      .done_o       (done[g])
    );

    assign state_out[2*g +: 2] = st;
    assign pulse[g]            = (st == ST_ACTIVE);
  end

  assign busy = |pulse;

endmodule

`default_nettype wire

// File: tb/tb_pulse_timer.sv
// ----------------------------------------------------------------------------
// | tb_pulse_timer                                                           |
// | Self-checking bench: directed vector table, corner sequences, random.    |
// | Revision: 1.0                                                            |
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_pulse_timer;

  localparam int CH = 4;
  localparam int CW = 8;
  localparam int TD = 4;
`ifdef PULSE_TIMER_RETRIG_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            en = 1'b1;
  logic [CH-1:0]   trig = '0;
  logic [CW-1:0]   hold = '0;
  logic [CH-1:0]   pulse;
  logic [CH-1:0]   done;
  logic            busy;
  logic            tick;
  logic [2*CH-1:0] state_out;

  int n_cmp = 0;
  int n_bad = 0;

  pulse_timer #(
    .CHANNELS (CH),
    .CNT_W    (CW),
    .TICK_DIV (TD)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .trig       (trig),
    .hold_ticks (hold),
    .pulse      (pulse),
    .done       (done),
    .busy       (busy),
    .tick       (tick),
    .state_out  (state_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Reference model: mode 0 idle, 1 active, 2 waiting for release; rem = ticks left.
  int m_mode [CH];
  int m_rem  [CH];
  bit m_done [CH];
  bit m_hist [CH][3];
  int m_encnt = 0;

  always @(posedge clk) begin : model
    bit              tk;
    bit              ts;
    bit              ts_prev;
    int              load;
    logic [CH-1:0]   ep;
    logic [CH-1:0]   ed;
    logic [2*CH-1:0] es;
    logic            et;
    tk   = en && ((m_encnt % TD) == TD - 1);
    load = (hold == 0) ? 1 : int'(hold);
    if (reset) begin
      m_encnt = 0;
      for (int c = 0; c < CH; c++) begin
        m_mode[c] = 0;
        m_rem[c]  = 0;
        m_done[c] = 1'b0;
        for (int h = 0; h < 3; h++) m_hist[c][h] = 1'b0;
      end
    end else begin
      for (int c = 0; c < CH; c++) begin
        ts        = m_hist[c][1];
        ts_prev   = m_hist[c][2];
        m_done[c] = 1'b0;
        case (m_mode[c])
          0: if (ts && en) begin
               m_mode[c] = 1;
               m_rem[c]  = load;
             end
          1: if (en) begin
               if (RETRIG && ts && !ts_prev) begin
                 m_rem[c] = load;
               end else if (tk) begin
                 m_rem[c] = m_rem[c] - 1;
                 if (m_rem[c] == 0) begin
                   m_mode[c] = ts ? 2 : 0;
                   m_done[c] = 1'b1;
                 end
               end
             end
          default: if (!ts) m_mode[c] = 0;
        endcase
        m_hist[c][2] = m_hist[c][1];
        m_hist[c][1] = m_hist[c][0];
        m_hist[c][0] = trig[c];
      end
      if (en) m_encnt++;
    end
    #1;
    for (int c = 0; c < CH; c++) begin
      ep[c]        = (m_mode[c] == 1);
      ed[c]        = m_done[c];
      es[2*c +: 2] = 2'(m_mode[c]);
    end
    et = en && ((m_encnt % TD) == TD - 1);
    check("cycle{pulse,done,busy,tick,state}",
          64'({pulse, done, busy, tick, state_out}),
          64'({ep, ed, |ep, et, es}));
  end

  typedef struct {
    int         ch;
    logic [7:0] hold;
    int         trig_len;
    int         off_at;
    int         off_len;
    int         min_len;
    int         max_len;
    bit         exp_wait;
    int         run_len;
  } vec_t;

  vec_t vecs [6];

  task automatic align();
    int k;
    k = 0;
    while (k < 20) begin
      @(posedge clk); #2;
      if (tick) break;
      k++;
    end
    n_cmp++;
    if (k >= 20) begin
      n_bad++;
      $display("FAIL align: got no tick in 20 cycles expected tick");
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int         plen;
    int         dcnt;
    bit         wseen;
    int         wexit;
    logic [1:0] st;
    plen  = 0;
    dcnt  = 0;
    wseen = 1'b0;
    wexit = -1;
    align();
    for (int k = 0; k < v.run_len; k++) begin
      @(negedge clk);
      hold        = v.hold;
      trig[v.ch]  = (k < v.trig_len);
      en          = !(k >= v.off_at && k < v.off_at + v.off_len);
      @(posedge clk); #2;
      if (pulse[v.ch]) plen++;
      if (done[v.ch]) dcnt++;
      st = state_out[2*v.ch +: 2];
      if (st == 2'b10) wseen = 1'b1;
      else if (wseen && wexit < 0 && st == 2'b00) wexit = k;
    end
    @(negedge clk);
    en         = 1'b1;
    trig[v.ch] = 1'b0;
    check_range($sformatf("vec%0d pulse_len", idx), plen, v.min_len, v.max_len);
    check($sformatf("vec%0d done_count", idx), 64'(dcnt), 64'd1);
    check($sformatf("vec%0d wait_seen", idx), 64'(wseen), 64'(v.exp_wait));
    if (v.exp_wait) check($sformatf("vec%0d wait_exit_iter", idx), 64'(wexit), 64'(v.trig_len + 2));
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    int plen;
    int dcnt;
    int k;

    //           ch hold trig off_at off_len min max wait run
    vecs[0] = '{0, 8'd3, 1,  0, 0,  9, 12, 1'b0, 30};
    vecs[1] = '{1, 8'd2, 40, 0, 0,  5,  8, 1'b1, 50};
    vecs[2] = '{2, 8'd0, 1,  0, 0,  1,  4, 1'b0, 15};
    vecs[3] = '{2, 8'd0, 1,  3, 10, 11, 14, 1'b0, 30};
    vecs[4] = '{3, 8'd1, 10, 0, 0,  1,  4, 1'b1, 20};
    vecs[5] = '{0, 8'd5, 3,  0, 0,  17, 20, 1'b0, 40};

    // Reset for three cycles: everything quiet, then tick on the 4th cycle.
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      @(posedge clk); #2;
      check("reset_outputs", 64'({pulse, done, busy, tick, state_out}), 64'd0);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #2;
      check($sformatf("tick_after_reset_cycle%0d", i + 2), 64'(tick), 64'(i == 2));
    end

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // Reset mid-pulse on channel 3 aborts without done.
    align();
    @(negedge clk);
    hold    = 8'd3;
    trig[3] = 1'b1;
    @(negedge clk);
    trig[3] = 1'b0;
    k = 0;
    while (k < 10) begin
      @(posedge clk); #2;
      if (pulse[3]) break;
      k++;
    end
    check("ch3_pulse_started", 64'(pulse[3]), 64'd1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #2;
    check("midreset_pulse3", 64'(pulse[3]), 64'd0);
    check("midreset_done3", 64'(done[3]), 64'd0);
    check("midreset_state3", 64'(state_out[7:6]), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    dcnt = 0;
    repeat (15) begin
      @(posedge clk); #2;
      if (done[3]) dcnt++;
    end
    check("midreset_no_done", 64'(dcnt), 64'd0);

`ifdef PULSE_TIMER_RETRIG_EN
    // Second press lands so its rising edge coincides with the final tick.
    align();
    plen = 0;
    dcnt = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      hold    = 8'd2;
      trig[0] = (i == 0 || i == 6);
      @(posedge clk); #2;
      if (pulse[0]) plen++;
      if (done[0]) dcnt++;
    end
    check("retrig_pulse_len", 64'(plen), 64'd14);
    check("retrig_done_count", 64'(dcnt), 64'd1);
`endif

    // Random traffic, checked cycle by cycle against the model.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      for (int c = 0; c < CH; c++) begin
        if (($urandom % 8) == 0) trig[c] = ~trig[c];
      end
      en    = (($urandom % 8) != 0);
      hold  = 8'($urandom % 4);
      reset = (($urandom % 300) == 0);
    end
    @(negedge clk);
    reset = 1'b0;
    en    = 1'b1;
    trig  = '0;
    repeat (4) @(posedge clk);
    #3;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
